// File: rtl/spi_config_sequencer_if.sv
// Configuration request bus and SPI pins of the configuration sequencer.
// The sequencer (slave) takes the start request and config and drives the SPI pins.
interface spi_config_sequencer_if;
    logic        start;
    logic [4:0]  frame_mask;
    logic [15:0] cfg_out_en;
    logic [15:0] cfg_pwm_en;
    logic [7:0]  cfg_duty;
    logic        SCLK;
    logic        COPI;
    logic        nCS;
    logic        busy;
    logic        done;

    modport master (
        output start, frame_mask, cfg_out_en, cfg_pwm_en, cfg_duty,
        input  SCLK, COPI, nCS, busy, done
    );

    modport slave (
        input  start, frame_mask, cfg_out_en, cfg_pwm_en, cfg_duty,
        output SCLK, COPI, nCS, busy, done
    );
endinterface

// File: rtl/spi_config_sequencer.sv
// Sweeps up to five 16-bit SPI write frames into the PWM/output-enable register bank
// from a config snapshot taken at start; SPI pins paced slowly for a 2-FF-synchronised peripheral.
module spi_config_sequencer #(
    parameter int unsigned HALF = 4,
    parameter int unsigned GAP  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    spi_config_sequencer_if.slave   bus
);
    localparam int unsigned SEG_W  = 8;
    localparam int unsigned BIT_W  = 4;
    localparam int unsigned FRM_W  = 3;
    localparam int unsigned NFRM   = 5;
    localparam int unsigned WORD_W = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_CS_SETUP, S_BIT_A, S_BIT_B, S_BIT_C, S_CS_HOLD, S_GAP, S_DONE
    } state_t;

    state_t             state, state_d;
    logic [SEG_W-1:0]   seg, seg_d;
    logic [BIT_W-1:0]   bit_idx, bit_d;
    logic [FRM_W-1:0]   frm, frm_d;
    logic [NFRM-1:0]    pend, pend_d;
    logic [15:0]        oe_q, oe_d, pe_q, pe_d;
    logic [7:0]         duty_q, duty_d;
    logic               sclk_q, copi_q, ncs_q, busy_q, done_q;
    logic               sclk_d, copi_d, ncs_d, busy_d, done_d;
    logic [7:0]         data_sel;
    logic [WORD_W-1:0]  word;
    logic               seg_last, gap_last, start_ok;

    function automatic logic [FRM_W-1:0] lowest(input logic [NFRM-1:0] m);
        lowest = '0;
        for (int i = int'(NFRM) - 1; i >= 0; i--) begin
            if (m[i]) lowest = FRM_W'(i);
        end
    endfunction

    assign seg_last = (seg == SEG_W'(HALF - 1));
    assign gap_last = (seg == SEG_W'(GAP - 1));
    // The done cycle is still part of the sweep from the requester's view, so start is refused there.
    assign start_ok = (state == S_IDLE) && bus.start && !done_q;

    always_comb begin
        state_d  = state;
        seg_d    = seg;
        bit_d    = bit_idx;
        frm_d    = frm;
        pend_d   = pend;
        oe_d     = oe_q;
        pe_d     = pe_q;
        duty_d   = duty_q;
        sclk_d   = 1'b0;
        copi_d   = 1'b0;
        ncs_d    = 1'b1;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        data_sel = '0;

        case (frm)
            3'd0:    data_sel = oe_q[7:0];
            3'd1:    data_sel = oe_q[15:8];
            3'd2:    data_sel = pe_q[7:0];
            3'd3:    data_sel = pe_q[15:8];
            default: data_sel = duty_q;
        endcase
        word = {1'b1, 7'(frm), data_sel};

        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    oe_d   = bus.cfg_out_en;
                    pe_d   = bus.cfg_pwm_en;
                    duty_d = bus.cfg_duty;
                    seg_d  = '0;
                    if (bus.frame_mask == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CS_SETUP;
                        frm_d   = lowest(bus.frame_mask);
                        pend_d  = bus.frame_mask & ~(NFRM'(1) << lowest(bus.frame_mask));
                        bit_d   = BIT_W'(WORD_W - 1);
                    end
                end
            end
            S_CS_SETUP, S_BIT_A, S_BIT_B: begin
                if (seg_last) begin
                    seg_d = '0;
                    case (state)
                        S_CS_SETUP: state_d = S_BIT_A;
                        S_BIT_A:    state_d = S_BIT_B;
                        default:    state_d = S_BIT_C;
                    endcase
                end else begin
                    seg_d = seg + SEG_W'(1);
                end
            end
            S_BIT_C: begin
                if (seg_last) begin
                    seg_d = '0;
                    if (bit_idx == '0) begin
                        state_d = S_CS_HOLD;
                    end else begin
                        bit_d   = bit_idx - BIT_W'(1);
                        state_d = S_BIT_A;
                    end
                end else begin
                    seg_d = seg + SEG_W'(1);
                end
            end
            S_CS_HOLD: begin
                if (seg_last) begin
                    seg_d   = '0;
                    state_d = (pend != '0) ? S_GAP : S_DONE;
                end else begin
                    seg_d = seg + SEG_W'(1);
                end
            end
            S_GAP: begin
                if (gap_last) begin
                    seg_d   = '0;
                    state_d = S_CS_SETUP;
                    frm_d   = lowest(pend);
                    pend_d  = pend & ~(NFRM'(1) << lowest(pend));
                    bit_d   = BIT_W'(WORD_W - 1);
                end else begin
                    seg_d = seg + SEG_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Pins follow the current state one cycle later; bit_idx only moves on BIT_A entry.
        if (state inside {S_CS_SETUP, S_BIT_A, S_BIT_B, S_BIT_C, S_CS_HOLD}) begin
            ncs_d  = 1'b0;
            copi_d = word[bit_idx];
        end
        sclk_d = (state == S_BIT_B);
        busy_d = (state == S_IDLE) ? start_ok : (state != S_DONE);
        done_d = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            seg     <= '0;
            bit_idx <= '0;
            frm     <= '0;
            pend    <= '0;
            oe_q    <= '0;
            pe_q    <= '0;
            duty_q  <= '0;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            ncs_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_d;
            seg     <= seg_d;
            bit_idx <= bit_d;
            frm     <= frm_d;
            pend    <= pend_d;
            oe_q    <= oe_d;
            pe_q    <= pe_d;
            duty_q  <= duty_d;
            sclk_q  <= sclk_d;
            copi_q  <= copi_d;
            ncs_q   <= ncs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.SCLK = sclk_q;
    assign bus.COPI = copi_q;
    assign bus.nCS  = ncs_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_spi_config_sequencer.sv
// Bench for spi_config_sequencer: per-cycle waveform model, SPI frame monitor, directed and random sweeps.
module tb_spi_config_sequencer;
    localparam int unsigned HALF = 4;
    localparam int unsigned GAP  = 8;
    localparam logic [4:0]  IDLE_PINS = 5'b00100;   // {SCLK,COPI,nCS,busy,done}

    logic clk;
    logic rst_n;
    spi_config_sequencer_if bus();

    spi_config_sequencer #(.HALF(HALF), .GAP(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
    endfunction

    function automatic logic [15:0] frame_word(input int i, input logic [15:0] oe,
                                               input logic [15:0] pe, input logic [7:0] duty);
        logic [7:0] d;
        case (i)
            0:       d = oe[7:0];
            1:       d = oe[15:8];
            2:       d = pe[7:0];
            3:       d = pe[15:8];
            default: d = duty;
        endcase
        return {1'b1, 7'(i), d};
    endfunction

    // Expected pin values, one entry per clock cycle of an accepted sweep.
    logic [4:0] q[$];

    function automatic void build(input logic [4:0] m, input logic [15:0] oe,
                                  input logic [15:0] pe, input logic [7:0] duty);
        logic [15:0] w;
        bit first;
        first = 1'b1;
        q.push_back(5'b00110);
        for (int i = 0; i < 5; i++) begin
            if (m[i]) begin
                w = frame_word(i, oe, pe, duty);
                if (!first) repeat (GAP) q.push_back(5'b00110);
                first = 1'b0;
                repeat (HALF) q.push_back({1'b0, w[15], 3'b010});
                for (int b = 15; b >= 0; b--) begin
                    repeat (HALF) q.push_back({1'b0, w[b], 3'b010});
                    repeat (HALF) q.push_back({1'b1, w[b], 3'b010});
                    repeat (HALF) q.push_back({1'b0, w[b], 3'b010});
                end
                repeat (HALF) q.push_back({1'b0, w[0], 3'b010});
            end
        end
        q.push_back(5'b00101);
    endfunction

    bit model_idle;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            model_idle = (q.size() == 0);
            if (!model_idle) void'(q.pop_front());
            if (model_idle && bus.start)
                build(bus.frame_mask, bus.cfg_out_en, bus.cfg_pwm_en, bus.cfg_duty);
        end
    end

    logic [4:0] exp_pins;
    always @(negedge clk) begin
        exp_pins = (!rst_n || q.size() == 0) ? IDLE_PINS : q[0];
        chk("pins{sclk,copi,ncs,busy,done}", 32'({bus.SCLK, bus.COPI, bus.nCS, bus.busy, bus.done}),
            32'(exp_pins));
    end

    // SPI monitor: decodes frames on rising SCLK while nCS low and measures window lengths.
    logic [15:0] rx[$];
    int lows[$];
    int gaps[$];
    int lo_len = 0, hi_len = 0, nbits = 0, aborted = 0, stray = 0, done_cnt = 0;
    logic [15:0] sh = '0;
    logic prev_sclk = 1'b0, prev_ncs = 1'b1;

    always @(negedge clk) begin
        if (!bus.nCS) begin
            if (prev_ncs) begin
                gaps.push_back(hi_len);
                lo_len = 1;
                nbits  = 0;
            end else begin
                lo_len++;
            end
            if (bus.SCLK && !prev_sclk) begin
                sh = {sh[14:0], bus.COPI};
                nbits++;
            end
        end else begin
            if (!prev_ncs) begin
                lows.push_back(lo_len);
                if (nbits == 16) rx.push_back(sh);
                else aborted++;
                hi_len = 1;
            end else begin
                hi_len++;
            end
            if (bus.SCLK && !prev_sclk) stray++;
        end
        if (bus.done) done_cnt++;
        prev_sclk = bus.SCLK;
        prev_ncs  = bus.nCS;
    end

    task automatic set_cfg(input logic [4:0] m, input logic [15:0] oe,
                           input logic [15:0] pe, input logic [7:0] duty);
        bus.frame_mask = m;
        bus.cfg_out_en = oe;
        bus.cfg_pwm_en = pe;
        bus.cfg_duty   = duty;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (n < budget && !seen) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            n++;
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic check_frames(input string name, input int r0, input logic [4:0] m,
                                input logic [15:0] oe, input logic [15:0] pe, input logic [7:0] duty);
        int k;
        k = r0;
        chk({name, "_frame_count"}, 32'(rx.size() - r0), 32'($countones(m)));
        for (int i = 0; i < 5; i++) begin
            if (m[i]) begin
                if (k < rx.size()) chk({name, "_frame"}, 32'(rx[k]), 32'(frame_word(i, oe, pe, duty)));
                k++;
            end
        end
    endtask

    int r0, l0, g0, d0, a0, nfr, len, dly;
    logic [15:0] full_exp [5];
    logic [4:0]  rm;
    logic [15:0] roe, rpe;
    logic [7:0]  rduty;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        full_exp[0] = 16'h805A;
        full_exp[1] = 16'h81A5;
        full_exp[2] = 16'h820F;
        full_exp[3] = 16'h830F;
        full_exp[4] = 16'h8480;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        set_cfg('0, '0, '0, '0);
        repeat (4) @(negedge clk);
        chk("reset_pins", 32'({bus.SCLK, bus.COPI, bus.nCS, bus.busy, bus.done}), 32'(5'b00100));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Full sweep with literal frame contents and timing.
        r0 = rx.size(); l0 = lows.size(); g0 = gaps.size(); d0 = done_cnt;
        set_cfg(5'h1F, 16'hA55A, 16'h0F0F, 8'h80);
        pulse_start();
        wait_done("full", 3000);
        repeat (3) @(negedge clk);
        chk("full_frame_count", 32'(rx.size() - r0), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (r0 + k < rx.size()) chk("full_frame", 32'(rx[r0 + k]), 32'(full_exp[k]));
            if (l0 + k < lows.size()) chk("full_cs_low_cycles", 32'(lows[l0 + k]), 32'd200);
            if (k > 0 && g0 + k < gaps.size()) chk("full_gap_cycles", 32'(gaps[g0 + k]), 32'd8);
        end
        chk("full_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Masked sweep: frames 1 and 4 only.
        r0 = rx.size(); g0 = gaps.size(); d0 = done_cnt;
        set_cfg(5'b10010, 16'h1234, 16'h5678, 8'h40);
        pulse_start();
        wait_done("masked", 3000);
        repeat (3) @(negedge clk);
        chk("masked_frame_count", 32'(rx.size() - r0), 32'd2);
        if (r0 + 1 < rx.size()) begin
            chk("masked_frame0", 32'(rx[r0]), 32'h8112);
            chk("masked_frame1", 32'(rx[r0 + 1]), 32'h8440);
        end
        if (g0 + 1 < gaps.size()) chk("masked_gap_cycles", 32'(gaps[g0 + 1]), 32'd8);

        // Empty mask: one busy cycle, done two cycles after start.
        r0 = rx.size(); l0 = lows.size(); d0 = done_cnt;
        set_cfg(5'b00000, 16'hFFFF, 16'hFFFF, 8'hFF);
        pulse_start();
        @(negedge clk);
        chk("empty_c1_busy_done", 32'({bus.busy, bus.done, bus.nCS}), 32'(3'b101));
        @(negedge clk);
        chk("empty_c2_busy_done", 32'({bus.busy, bus.done, bus.nCS}), 32'(3'b011));
        repeat (3) @(negedge clk);
        chk("empty_no_frames", 32'(lows.size() - l0), 32'd0);
        chk("empty_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Snapshot: changed config and a second start mid-sweep are ignored.
        r0 = rx.size(); d0 = done_cnt;
        set_cfg(5'h1F, 16'hA55A, 16'h0F0F, 8'h80);
        pulse_start();
        repeat (300) @(posedge clk);
        set_cfg(5'h01, 16'h0000, 16'hFFFF, 8'hFF);
        pulse_start();
        wait_done("snapshot", 3000);
        repeat (3) @(negedge clk);
        chk("snapshot_frame_count", 32'(rx.size() - r0), 32'd5);
        if (r0 + 4 < rx.size()) chk("snapshot_duty_frame", 32'(rx[r0 + 4]), 32'h8480);
        chk("snapshot_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Reset during the 8th bit of frame 2.
        r0 = rx.size(); d0 = done_cnt; a0 = aborted;
        set_cfg(5'h1F, 16'hA55A, 16'h0F0F, 8'h80);
        pulse_start();
        repeat (1 + 2 * (50 * HALF + GAP) + 22 * HALF + 5) @(posedge clk);
        chk("pre_reset_frames", 32'(rx.size() - r0), 32'd2);
        chk("pre_reset_bits", 32'(nbits), 32'd8);
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset_abort_pins", 32'({bus.SCLK, bus.nCS, bus.busy, bus.done}), 32'(4'b0100));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_no_done", 32'(done_cnt - d0), 32'd0);
        chk("reset_aborted_frame", 32'(aborted - a0), 32'd1);
        r0 = rx.size();
        pulse_start();
        wait_done("post_reset", 3000);
        repeat (3) @(negedge clk);
        check_frames("post_reset", r0, 5'h1F, 16'hA55A, 16'h0F0F, 8'h80);

        // Random sweeps, with stray starts mid-sweep and one start in the done cycle.
        for (int it = 0; it < 8; it++) begin
            rm    = 5'($urandom_range(0, 31));
            roe   = 16'($urandom);
            rpe   = 16'($urandom);
            rduty = 8'($urandom);
            r0 = rx.size(); d0 = done_cnt;
            set_cfg(rm, roe, rpe, rduty);
            pulse_start();
            nfr = $countones(rm);
            len = 2 + nfr * 50 * int'(HALF) + ((nfr > 0) ? (nfr - 1) * int'(GAP) : 0);
            if (nfr > 0 && (it % 2) == 1) begin
                dly = $urandom_range(1, len - 5);
                repeat (dly) @(posedge clk);
                set_cfg(5'($urandom), 16'($urandom), 16'($urandom), 8'($urandom));
                pulse_start();
            end
            wait_done("random", 3000);
            if (it == 2) begin
                bus.start = 1'b1;
                @(posedge clk); #1;
                bus.start = 1'b0;
                repeat (2) @(negedge clk);
                chk("done_cycle_start_ignored", 32'(bus.busy), 32'd0);
            end
            repeat (3) @(negedge clk);
            check_frames("random", r0, rm, roe, rpe, rduty);
            chk("random_done_pulses", 32'(done_cnt - d0), 32'd1);
        end

        chk("no_sclk_while_ncs_high", 32'(stray), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/spi_config_sequencer.md
Name: spi_config_sequencer

Overview:
- On-chip SPI controller that programs the SPI-attached PWM/output-enable register bank without an external host.
- On a start pulse it latches a configuration snapshot and issues up to five 16-bit SPI write frames, one per register: output enable [7:0] and [15:8], PWM enable [7:0] and [15:8], and PWM duty cycle.
- SCLK/COPI/nCS are driven slowly enough for a peripheral that runs on the same clk and uses a 2-FF synchroniser plus edge detection.

Parameters:
HALF, 4, clk cycles per SCLK phase segment; legal range 4..255
GAP, 8, clk cycles nCS held high between consecutive frames; legal range 2..255

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a sweep; ignored while busy=1
frame_mask  input  5  bit i=1 enables frame i (address i); sampled with start
cfg_out_en  input  16  output-enable value; sampled with start
cfg_pwm_en  input  16  PWM-enable value; sampled with start
cfg_duty  input  8  PWM duty cycle; sampled with start
SCLK  output  1  SPI clock, idle low
COPI  output  1  SPI data, MSB first
nCS  output  1  SPI chip select, active low
busy  output  1  sweep in progress
done  output  1  one-cycle pulse at sweep completion

Behaviour:
- Reset is asynchronous, active-low (rst_n); clock is clk. Under reset: SCLK=0, COPI=0, nCS=1, busy=0, done=0, state=IDLE, all counters and latched config cleared.
- Frame i layout, MSB first: bit15=1 (write), bits[14:8]=7'(i), bits[7:0]=data.
- Frame data: i=0 cfg_out_en[7:0]; i=1 cfg_out_en[15:8]; i=2 cfg_pwm_en[7:0]; i=3 cfg_pwm_en[15:8]; i=4 cfg_duty.
- Frames are sent in ascending i. Masked-off frames consume zero cycles.
- States: IDLE, CS_SETUP, BIT_A, BIT_B, BIT_C, CS_HOLD, GAP, DONE.
- IDLE, start=1: latch mask and cfg, set busy=1 next cycle.
  - If mask=0, go to DONE.
  - Otherwise select the lowest enabled frame and go to CS_SETUP.
- CS_SETUP: nCS=0, SCLK=0, COPI=frame bit15; lasts HALF cycles, then BIT_A.
- Each bit is three segments of HALF cycles:
  - BIT_A: SCLK=0, COPI=current bit.
  - BIT_B: SCLK=1, COPI held.
  - BIT_C: SCLK=0, COPI held.
  - After BIT_C: if bits remain, BIT_A with the next bit; otherwise CS_HOLD.
- COPI changes only on BIT_A entry. Both SCLK edges see at least HALF stable cycles of COPI.
- CS_HOLD: nCS=0, SCLK=0 for HALF cycles. This lets the peripheral commit while nCS is still low.
  - Then GAP if a further enabled frame exists, else DONE.
- nCS-low time per frame is exactly 50*HALF cycles (HALF + 48*HALF + HALF).
- GAP: nCS=1, SCLK=0, COPI=0 for GAP cycles, then CS_SETUP for the next enabled frame.
- DONE: one cycle with done=1, busy=0, nCS=1; then IDLE. A start in the DONE cycle is ignored.
- start during busy: ignored. Latched config is immune to input changes mid-sweep.
- Reset mid-frame: outputs return immediately to idle values (nCS=1 aborts the frame at the peripheral); no done pulse.
- Exactly 16 rising SCLK edges per frame; no SCLK edges while nCS=1.
- Counters:
  - segment counter 8 bits, counts 0..HALF-1 or 0..GAP-1
  - bit index 4 bits, counts 15 down to 0
  - frame index 3 bits

Test Plan:
- Reset values: hold rst_n=0 -> SCLK=0, COPI=0, nCS=1, busy=0, done=0.
- Full sweep: HALF=4, GAP=8, mask=5'h1F, cfg_out_en=16'hA55A, cfg_pwm_en=16'h0F0F, cfg_duty=8'h80, start pulse.
  - Bench SPI monitor decodes frames 16'h805A, 16'h81A5, 16'h820F, 16'h830F, 16'h8480, in that order.
  - Each nCS-low window is 200 cycles; each inter-frame gap is 8 cycles.
  - done pulses once; busy is high from the cycle after start until done.
- Masked sweep: mask=5'b10010, cfg_out_en=16'h1234, cfg_duty=8'h40 -> only 16'h8112 then 16'h8440 sent; done follows the second frame's CS_HOLD.
- Empty mask: mask=0, start -> no nCS activity; done=1 exactly 2 cycles after start, busy high for 1 cycle.
- Ignore and snapshot: change cfg_duty to 8'hFF and pulse start mid-sweep -> frame 4 still carries the originally latched duty; exactly one done pulse.
- Reset mid-frame: assert rst_n=0 during the 8th bit of frame 2 -> nCS=1, SCLK=0 immediately, no done; a new start afterwards produces a clean full sweep.
- End-to-end: connect the block to the team's SPI peripheral, then run the full sweep -> peripheral registers read 8'h5A, 8'hA5, 8'h0F, 8'h0F, 8'h80.
